// File: rtl/branch_pkg.sv
// Shared definitions for the pattern-history-table branch predictor.
//   OPC_BRANCH  : RV32I B-type major opcode
//   pht_entries : number of PHT entries for a given index width
//   sat_update  : one step of an N-bit saturating up/down counter
package branch_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  function automatic int unsigned pht_entries(input int unsigned index_w);
    return 32'd1 << index_w;
  endfunction

  // Counter value is carried zero-extended in 32 bits so one function serves
  // every CTR_W; callers cast the result back to their own width.
  function automatic logic [31:0] sat_update(input logic [31:0]  ctr,
                                             input logic         taken,
                                             input int unsigned  ctr_w);
    logic [31:0] max_val;
    max_val = (32'd1 << ctr_w) - 32'd1;
    if (taken) return (ctr == max_val) ? ctr : ctr + 32'd1;
    return (ctr == 32'd0) ? ctr : ctr - 32'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_pht_sat_counter.sv
// One PHT entry: CTR_W-bit saturating counter with asynchronous reset.
//   clk, reset : clock, async active-high reset (loads CTR_INIT)
//   update_i   : train this entry on the current edge
//   taken_i    : resolved direction (1 = count up, 0 = count down)
//   ctr_o      : current counter value
module sat_counter
  import branch_pkg::*;
#(
  parameter int unsigned CTR_W    = 2,
  parameter int unsigned CTR_INIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             update_i,
  input  logic             taken_i,
  output logic [CTR_W-1:0] ctr_o
);

  logic [CTR_W-1:0] ctr_q;
  logic [CTR_W-1:0] ctr_d;

  assign ctr_d = CTR_W'(sat_update(32'(ctr_q), taken_i, CTR_W));

  // NOTE: the table is built from flops rather than an SRAM precisely so every
  // entry can be returned to CTR_INIT by reset; memories normally are not reset.
  // NOTE: sequential state uses non-blocking assignment so all flops see the
  // pre-edge values of their neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctr_q <= CTR_W'(CTR_INIT);
    end else if (update_i) begin
      ctr_q <= ctr_d;
    end
  end

  assign ctr_o = ctr_q;

endmodule

// File: rtl/branch_predictor_pht.sv
// Pattern-history-table branch predictor.
// Lookup from IF (1-cycle latency, prediction registered for ID); training
// from EX with a write-forwarding path when lookup and update hit the same
// entry on the same edge. Also counts mispredictions (saturating, 32 bits).
//   lookup_valid/lookup_is_branch/lookup_pc : IF lookup request
//   pred_valid/pred_taken/pred_index        : registered prediction for ID
//   update_valid/update_index/update_taken/update_mispredict : EX training
//   mispredict_count                        : saturating misprediction count
// Optional build macro BRANCH_PREDICTOR_GSHARE_EN: XOR a HIST_W-bit global
// history register into the lookup index (gshare). Undefined: bimodal.
module branch_predictor_pht
  import branch_pkg::*;
#(
  parameter int unsigned PC_W     = 32,
  parameter int unsigned INDEX_W  = 6,
  parameter int unsigned CTR_W    = 2,
  parameter int unsigned CTR_INIT = 1,
  parameter int unsigned HIST_W   = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               lookup_valid,
  input  logic               lookup_is_branch,
  input  logic [PC_W-1:0]    lookup_pc,
  output logic               pred_valid,
  output logic               pred_taken,
  output logic [INDEX_W-1:0] pred_index,
  input  logic               update_valid,
  input  logic [INDEX_W-1:0] update_index,
  input  logic               update_taken,
  input  logic               update_mispredict,
  output logic [31:0]        mispredict_count
);

  localparam int unsigned ENTRIES = pht_entries(INDEX_W);

  logic [CTR_W-1:0]   ctr_q [ENTRIES];
  logic [INDEX_W-1:0] idx;
  logic [CTR_W-1:0]   upd_ctr_nxt;
  logic [CTR_W-1:0]   lookup_ctr;

  logic               pred_valid_q;
  logic               pred_taken_q;
  logic [INDEX_W-1:0] pred_index_q;
  logic [31:0]        miss_cnt_q;
  logic [31:0]        miss_cnt_d;

  // PC bits outside the index field carry no information for the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[PC_W-1:INDEX_W+2], lookup_pc[1:0]};

  for (genvar g = 0; g < ENTRIES; g++) begin : g_pht
    sat_counter #(
      .CTR_W   (CTR_W),
      .CTR_INIT(CTR_INIT)
    ) u_ctr (
      .clk     (clk),
      .reset   (reset),
      .update_i(update_valid && (update_index == INDEX_W'(g))),
      .taken_i (update_taken),
      .ctr_o   (ctr_q[g])
    );
  end

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [HIST_W-1:0] ghr_q;

  // Shift the resolved outcome in at the LSB; the cast keeps the low HIST_W
  // bits, which also covers HIST_W=1 (GHR simply becomes update_taken).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr_q <= '0;
    end else if (update_valid) begin
      ghr_q <= HIST_W'({ghr_q, update_taken});
    end
  end

  // Registered GHR: a same-edge history update does not affect this index.
  assign idx = lookup_pc[INDEX_W+1:2] ^ INDEX_W'(ghr_q);
`else
  localparam int unsigned unused_hist_w = HIST_W;
  assign idx = lookup_pc[INDEX_W+1:2];
`endif

  // Forward the post-training value when the lookup hits the entry being
  // trained on this edge; otherwise the stored value is already current.
  assign upd_ctr_nxt = CTR_W'(sat_update(32'(ctr_q[update_index]), update_taken, CTR_W));
  assign lookup_ctr  = (update_valid && (update_index == idx)) ? upd_ctr_nxt : ctr_q[idx];

  assign miss_cnt_d = (update_valid && update_mispredict && (miss_cnt_q != '1))
                      ? miss_cnt_q + 32'd1 : miss_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_index_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      pred_valid_q <= lookup_valid;
      pred_taken_q <= lookup_valid & lookup_is_branch & lookup_ctr[CTR_W-1];
      if (lookup_valid) pred_index_q <= idx;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign pred_valid       = pred_valid_q;
  assign pred_taken       = pred_taken_q;
  assign pred_index       = pred_index_q;
  assign mispredict_count = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor_pht.sv
// Self-checking bench for branch_predictor_pht (default parameters).
// Directed scenarios followed by randomized lookups/updates, all compared
// against a behavioural table model; honours BRANCH_PREDICTOR_GSHARE_EN.
module tb_branch_predictor_pht;

  localparam int CMAX  = 3;   // 2^CTR_W - 1
  localparam int CINIT = 1;
  localparam int TAKEN_THR = 2; // counter >= this predicts taken

  logic        clk = 1'b0;
  logic        reset;
  logic        lookup_valid;
  logic        lookup_is_branch;
  logic [31:0] lookup_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic [5:0]  pred_index;
  logic        update_valid;
  logic [5:0]  update_index;
  logic        update_taken;
  logic        update_mispredict;
  logic [31:0] mispredict_count;

  always #5 clk = ~clk;

  branch_predictor_pht dut (
    .clk              (clk),
    .reset            (reset),
    .lookup_valid     (lookup_valid),
    .lookup_is_branch (lookup_is_branch),
    .lookup_pc        (lookup_pc),
    .pred_valid       (pred_valid),
    .pred_taken       (pred_taken),
    .pred_index       (pred_index),
    .update_valid     (update_valid),
    .update_index     (update_index),
    .update_taken     (update_taken),
    .update_mispredict(update_mispredict),
    .mispredict_count (mispredict_count)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Behavioural model state.
  int      ctr_m [64];
  int      ghr_m;
  longint  cnt_m;
  int      exp_valid, exp_taken, exp_index;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int train(input int c, input logic t);
    if (t) return (c < CMAX) ? c + 1 : c;
    return (c > 0) ? c - 1 : 0;
  endfunction

  function automatic int model_idx(input logic [31:0] pc);
    int i;
    i = int'((pc >> 2) % 64);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    i = i ^ ghr_m;
`endif
    return i;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) ctr_m[i] = CINIT;
    ghr_m = 0; cnt_m = 0;
    exp_valid = 0; exp_taken = 0; exp_index = 0;
  endtask

  task automatic idle_inputs();
    lookup_valid = 0; lookup_is_branch = 0; lookup_pc = '0;
    update_valid = 0; update_index = '0; update_taken = 0; update_mispredict = 0;
  endtask

  task automatic check_outputs();
    check("pred_valid", pred_valid, 64'(exp_valid));
    check("pred_taken", pred_taken, 64'(exp_taken));
    check("pred_index", pred_index, 64'(exp_index));
    check("mispredict_count", mispredict_count, 64'(cnt_m));
  endtask

  // One clock: apply inputs, advance the model, compare after the edge.
  task automatic cycle(input logic lv, input logic br, input logic [31:0] pc,
                       input logic uv, input logic [5:0] ui, input logic ut,
                       input logic um);
    int i, c;
    lookup_valid = lv; lookup_is_branch = br; lookup_pc = pc;
    update_valid = uv; update_index = ui; update_taken = ut; update_mispredict = um;
    i = model_idx(pc);
    c = ctr_m[i];
    if (uv && int'(ui) == i) c = train(c, ut);
    exp_valid = lv ? 1 : 0;
    exp_taken = (lv && br && c >= TAKEN_THR) ? 1 : 0;
    if (lv) exp_index = i;
    if (uv) begin
      ctr_m[ui] = train(ctr_m[ui], ut);
      ghr_m = ((ghr_m << 1) | int'(ut)) & 63;
      if (um && cnt_m < 64'hFFFF_FFFF) cnt_m++;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // Asynchronous reset away from the clock edge; outputs must clear at once.
  task automatic async_reset();
    reset = 1'b1;
    #1;
    check("rst_valid", pred_valid, 0);
    check("rst_taken", pred_taken, 0);
    check("rst_index", pred_index, 0);
    check("rst_count", mispredict_count, 0);
    model_reset();
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    reset = 1'b1;
    #2;
    async_reset();

    // Fresh entry at CTR_INIT predicts not-taken.
    cycle(1, 1, 32'h40, 0, 0, 0, 0);
`ifndef BRANCH_PREDICTOR_GSHARE_EN
    check("plan_first_taken", pred_taken, 0);
    check("plan_first_index", pred_index, 6'h10);
    check("plan_first_valid", pred_valid, 1);
`endif
    // Train 0x10 twice taken -> 3, then saturate, then step down to 2.
    cycle(0, 0, 0, 1, 6'h10, 1, 0);
    cycle(0, 0, 0, 1, 6'h10, 1, 0);
    cycle(1, 1, 32'h40, 0, 0, 0, 0);
`ifndef BRANCH_PREDICTOR_GSHARE_EN
    check("plan_trained_taken", pred_taken, 1);
`endif
    cycle(0, 0, 0, 1, 6'h10, 1, 0);
    cycle(0, 0, 0, 1, 6'h10, 0, 0);
    cycle(1, 1, 32'h40, 0, 0, 0, 0);
`ifndef BRANCH_PREDICTOR_GSHARE_EN
    check("plan_sat_hi_taken", pred_taken, 1);
`endif
    // Mid-stream reset while a taken prediction is showing.
    async_reset();
    cycle(1, 1, 32'h40, 0, 0, 0, 0);
    check("plan_after_reset", pred_taken, 0);
    // Same-cycle lookup and update on the same entry: forwarded.
    cycle(1, 1, 32'h40, 1, 6'h10, 1, 0);
`ifndef BRANCH_PREDICTOR_GSHARE_EN
    check("plan_forward", pred_taken, 1);
`endif
    cycle(0, 0, 0, 1, 6'h10, 1, 0);
    cycle(1, 0, 32'h40, 0, 0, 0, 0);
    check("plan_not_branch", pred_taken, 0);
    // Low-end saturation on 0x05.
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1, 6'h05, 0, 0);
    cycle(1, 1, 32'h14, 0, 0, 0, 0);
`ifndef BRANCH_PREDICTOR_GSHARE_EN
    check("plan_sat_lo", pred_taken, 0);
`endif

    // Three mispredicts T,T,N from reset.
    async_reset();
    cycle(0, 0, 0, 1, 6'h20, 1, 1);
    cycle(0, 0, 0, 1, 6'h20, 1, 1);
    cycle(0, 0, 0, 1, 6'h20, 0, 1);
    cycle(1, 1, 32'h40, 0, 0, 0, 0);
    check("plan_miss_count", mispredict_count, 3);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    check("plan_gshare_index", pred_index, 6'h16);
`endif
    // Ignored mispredict flag without update_valid.
    cycle(0, 0, 0, 0, 6'h20, 0, 1);

    // Randomized traffic concentrated on a few entries.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pc;
      pc = ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2);
      cycle(1'($urandom), 1'($urandom), pc, 1'($urandom), 6'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom));
      if (n % 150 == 149) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/branch_predictor_pht.md
Name: branch_predictor_pht

Overview:
Parametrised pattern-history-table (PHT) branch predictor for the RISC-V pipeline.
- Replaces the single global 2-bit saturating counter with a table of 2^INDEX_W N-bit saturating counters, indexed by fetch PC.
- Lookup is issued from IF. The prediction is registered for ID. Training arrives from EX when the branch resolves.
- Also keeps a saturating misprediction counter for performance monitoring.

Parameters:
PC_W, 32, program counter width
INDEX_W, 6, PHT index width; ENTRIES = 2^INDEX_W
CTR_W, 2, saturating counter width (>=1)
CTR_INIT, 1, counter reset value (1 = weakly not-taken for CTR_W=2); must be < 2^CTR_W
HIST_W, 6, global history length; must be <= INDEX_W (used only with GSHARE_EN)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
lookup_valid  in  1  IF-stage lookup request
lookup_is_branch  in  1  fetched instruction is B-type (beq/bne/blt/bge/bltu/bgeu)
lookup_pc  in  PC_W  fetch PC
pred_valid  out  1  prediction valid (ID stage)
pred_taken  out  1  predicted direction; 1 = taken
pred_index  out  INDEX_W  PHT index used; carried down the pipe to EX
update_valid  in  1  branch resolved in EX
update_index  in  INDEX_W  index returned with the branch
update_taken  in  1  actual outcome
update_mispredict  in  1  prediction was wrong (EX compare)
mispredict_count  out  32  saturating count of mispredictions

Behaviour:
- Reset (async, active-high):
  - all PHT entries <= CTR_INIT; GHR <= 0
  - pred_valid, pred_taken, pred_index, mispredict_count <= 0
  - Reset mid-operation discards any in-flight lookup or update.
- Storage: flop-based array (ENTRIES x CTR_W) so it can be async-reset; no SRAM.
- Index (combinational from lookup_pc): idx = lookup_pc[INDEX_W+1:2]. PC[1:0] is ignored; no compressed ISA.
- Lookup latency is 1 cycle. On a rising edge with lookup_valid=1:
  - pred_valid <= 1
  - pred_index <= idx
  - pred_taken <= lookup_is_branch & MSB(counter[idx])
- Lookup with lookup_is_branch=0: pred_taken <= 0. pred_index is still captured.
- Cycle with lookup_valid=0: pred_valid <= 0; pred_taken <= 0; pred_index holds.
- Update (rising edge, update_valid=1), applied to ctr = counter[update_index]:
  - update_taken=1: ctr <= (ctr == 2^CTR_W-1) ? ctr : ctr+1
  - update_taken=0: ctr <= (ctr == 0) ? 0 : ctr-1
  - Saturation is mandatory; no wrap at either end.
- Mispredict counter: update_valid & update_mispredict -> mispredict_count +1, saturating at 32'hFFFF_FFFF. update_mispredict is ignored when update_valid=0.
- Read/write same cycle, same index (lookup idx == update_index): prediction uses the post-update counter value (write-forwarding).
- Different indices in the same cycle are fully independent.
- Only one update per cycle. Training is non-speculative (EX only); no recovery state is needed.

Optional Feature:
BRANCH_PREDICTOR_GSHARE_EN
- Defined:
  - HIST_W-bit global history register GHR. On update_valid: GHR <= {GHR[HIST_W-2:0], update_taken}; HIST_W=1 loads update_taken directly.
  - Lookup index = lookup_pc[INDEX_W+1:2] XOR zero-extended GHR.
  - The GHR value used is the value before any same-edge update (registered read).
  - Forwarding still compares the final XORed idx against update_index.
- Undefined: no GHR; pure bimodal index.
- update_index semantics are identical in both builds (the stored index is used verbatim).

Decomposition:
- Shared package branch_pkg:
  - B-type opcode constant OPC_BRANCH = 7'b1100011
  - function sat_update(ctr, taken) parametrised on CTR_W
  - localparam helpers for ENTRIES
- One natural sub-module: sat_counter (CTR_W, CTR_INIT). It holds one entry with async reset and the inc/dec-saturate logic, generated ENTRIES times.
- Index/forwarding/GHR logic stays in the top.

Test Plan:
- Reset, then lookup pc=0x0000_0040 branch -> next cycle pred_valid=1, pred_taken=0 (CTR_INIT=1), pred_index=6'h10.
- Two updates idx=0x10 taken, then lookup pc=0x40 -> pred_taken=1. Third taken update, counter stays 3. A single not-taken update takes it to 2 -> still taken.
- Four not-taken updates on idx=0x05 from reset -> counter saturates at 0, no wrap to 3. Lookup pc=0x14 -> pred_taken=0.
- Same-cycle lookup pc=0x40 with update idx=0x10 taken from counter=1 -> pred_taken=1 (forwarded).
- Lookup with lookup_is_branch=0 on a taken-trained entry -> pred_taken=0. Assert reset mid-stream -> all outputs 0 immediately and the trained entry is back to CTR_INIT.
- With BRANCH_PREDICTOR_GSHARE_EN, HIST_W=6:
  - After updates T,T,N: GHR=6'b000110, so lookup pc=0x40 -> pred_index=0x16.
  - 3 updates with update_mispredict=1 -> mispredict_count=3.
